// File: rtl/fp32_addsub_seq.sv
// Multi-cycle fp32 add/subtract: align, mantissa add, then one-bit-per-cycle normalise; truncating, denormals flush to zero.
// Latency: 4 + n cycles for n normalisation shifts (overflow skips NORM); one operation in flight at a time.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module fp32_addsub_seq (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a_operand,
   input  logic [31:0] b_operand,
   input  logic        AddBar_Sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        Exception,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t      state;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        op_sub;
   logic        exc_in;
   logic        sign_r;
   logic        eff_sub;
   logic [7:0]  exp_r;
   logic [23:0] mant_x;
   logic [23:0] mant_y;

   // Alignment datapath: operand B carries its effective sign so the rest of the flow is a pure add.
   logic        b_sign_eff;
   logic        swap;
   logic [31:0] big_op;
   logic [31:0] sml_op;
   logic [23:0] big_m;
   logic [23:0] sml_m;
   logic [23:0] sml_sh;
   logic [7:0]  exp_diff;

   always_comb begin
      b_sign_eff = op_b[31] ^ op_sub;
      swap       = op_b[30:0] > op_a[30:0];
      big_op     = swap ? {b_sign_eff, op_b[30:0]} : op_a;
      sml_op     = swap ? op_a : {b_sign_eff, op_b[30:0]};
      big_m      = (big_op[30:23] == 8'd0) ? 24'd0 : {1'b1, big_op[22:0]};
      sml_m      = (sml_op[30:23] == 8'd0) ? 24'd0 : {1'b1, sml_op[22:0]};
      exp_diff   = big_op[30:23] - sml_op[30:23];
      sml_sh     = (exp_diff >= 8'd24) ? 24'd0 : (sml_m >> exp_diff);
   end

   // mant_x is never smaller than mant_y, so the subtract cannot borrow.
   logic [24:0] sum;

   always_comb begin
      if (eff_sub)
         sum = {1'b0, mant_x} - {1'b0, mant_y};
      else
         sum = {1'b0, mant_x} + {1'b0, mant_y};
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         result    <= 32'd0;
         Exception <= 1'b0;
         op_a      <= 32'd0;
         op_b      <= 32'd0;
         op_sub    <= 1'b0;
         exc_in    <= 1'b0;
         sign_r    <= 1'b0;
         eff_sub   <= 1'b0;
         exp_r     <= 8'd0;
         mant_x    <= 24'd0;
         mant_y    <= 24'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a     <= a_operand;
                  op_b     <= b_operand;
                  op_sub   <= AddBar_Sub;
                  exc_in   <= (a_operand[30:23] == 8'hFF) || (b_operand[30:23] == 8'hFF);
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ALIGN;
               end
            end

            ALIGN: begin
               sign_r  <= big_op[31];
               eff_sub <= big_op[31] ^ sml_op[31];
               exp_r   <= big_op[30:23];
               mant_x  <= big_m;
               mant_y  <= sml_sh;
               state   <= ADD;
            end

            ADD: begin
               if (exc_in) begin
                  state <= NORM;
               end else if (sum[24]) begin
                  if (exp_r == 8'd254) begin
                     result    <= {sign_r, 8'hFF, 23'd0};
                     Exception <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     mant_x <= sum[24:1];
                     exp_r  <= exp_r + 8'd1;
                     state  <= NORM;
                  end
               end else begin
                  mant_x <= sum[23:0];
                  state  <= NORM;
               end
            end

            NORM: begin
               if (exc_in) begin
                  result    <= 32'd0;
                  Exception <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (mant_x == 24'd0) begin
                  result    <= 32'd0;
                  Exception <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (mant_x[23]) begin
                  result    <= {sign_r, exp_r, mant_x[22:0]};
                  Exception <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (exp_r <= 8'd1) begin
                  // Another shift would take the exponent to zero: flush to +0 silently.
                  result    <= 32'd0;
                  Exception <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  mant_x <= {mant_x[22:0], 1'b0};
                  exp_r  <= exp_r - 8'd1;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_addsub_seq.sv
// Randomised bench for fp32_addsub_seq: numeric reference model plus literal pins, handshake and reset checks.
module tb_fp32_addsub_seq;

   logic        CLK = 1'b0;
   logic        RESETn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a_operand = 32'd0;
   logic [31:0] b_operand = 32'd0;
   logic        AddBar_Sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        Exception;
   logic        busy;

   fp32_addsub_seq dut (
      .CLK(CLK), .RESETn(RESETn), .in_valid(in_valid), .in_ready(in_ready),
      .a_operand(a_operand), .b_operand(b_operand), .AddBar_Sub(AddBar_Sub),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .Exception(Exception), .busy(busy)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired, got no response, expected handshake (t=%0t)", nm, $time);
   endtask

   // Reference: numeric meaning of the operation with truncation, flush-to-zero and the unit's cycle cost.
   function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  output logic [31:0] r, output logic exc, output int lat, output bit ovf);
      int     ea, eb, e_big, e_sml, d, ex;
      longint ma, mb, m_big, m_sml, m;
      logic   sa, sb, s;
      sa = a[31];
      sb = b[31] ^ sub;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      r = 32'd0; exc = 1'b0; lat = 4; ovf = 1'b0;
      if (ea == 255 || eb == 255) begin
         exc = 1'b1;
         return;
      end
      ma = (ea == 0) ? 0 : (longint'(a[22:0]) + 8388608);
      mb = (eb == 0) ? 0 : (longint'(b[22:0]) + 8388608);
      if (b[30:0] > a[30:0]) begin
         m_big = mb; e_big = eb; m_sml = ma; e_sml = ea; s = sb;
      end else begin
         m_big = ma; e_big = ea; m_sml = mb; e_sml = eb; s = sa;
      end
      d = e_big - e_sml;
      m_sml = (d >= 24) ? 0 : (m_sml >> d);
      m = (sa == sb) ? (m_big + m_sml) : (m_big - m_sml);
      ex = e_big;
      if (m >= 16777216) begin
         m = m / 2;
         ex++;
         if (ex == 255) begin
            ovf = 1'b1; exc = 1'b1; lat = 3;
            r = {s, 8'hFF, 23'd0};
            return;
         end
      end
      if (m == 0) return;
      while (m < 8388608 && ex > 1) begin
         m = m * 2;
         ex--;
         lat++;
      end
      if (m >= 8388608) r = {s, 8'(ex), 23'(m)};
   endfunction

   // Compare process: one transaction in flight, checked on every cycle.
   bit          pending = 1'b0;
   bit          seen = 1'b0;
   int          cyc = 0;
   logic [31:0] exp_res;
   logic        exp_exc;
   int          exp_lat;
   bit          exp_ovf;
   logic [31:0] last_res = 32'd0;
   logic        last_exc = 1'b0;
   int          last_lat = 0;

   initial begin : compare
      forever begin
         @(negedge CLK);
         if (!RESETn) begin
            pending = 1'b0;
            continue;
         end
         if (pending) begin
            cyc++;
            if (out_valid) begin
               if (!seen) begin
                  seen = 1'b1;
                  last_lat = cyc;
                  if (!exp_ovf) chk("latency", 32'(cyc), 32'(exp_lat));
               end
               chk("result", result, exp_res);
               chk1("exception", Exception, exp_exc);
               chk1("in_ready_done", in_ready, 1'b0);
               if (out_ready) begin
                  pending = 1'b0;
                  last_res = result;
                  last_exc = Exception;
               end
            end else begin
               chk1("busy_inflight", busy, 1'b1);
               chk1("in_ready_inflight", in_ready, 1'b0);
               if (cyc > 40) begin
                  timeout_fail("out_valid_wait");
                  pending = 1'b0;
               end
            end
         end else begin
            chk1("idle_out_valid", out_valid, 1'b0);
            chk1("idle_in_ready", in_ready, 1'b1);
            chk1("idle_busy", busy, 1'b0);
         end
         if (in_valid && in_ready) begin
            pending = 1'b1;
            seen = 1'b0;
            cyc = 0;
            ref_op(a_operand, b_operand, AddBar_Sub, exp_res, exp_exc, exp_lat, exp_ovf);
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
      int t = 0;
      while (!in_ready && t < 100) begin
         @(posedge CLK); #1;
         t++;
      end
      if (!in_ready) timeout_fail("send_in_ready");
      a_operand = a; b_operand = b; AddBar_Sub = sub; in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      a_operand = $urandom; b_operand = $urandom; AddBar_Sub = 1'($urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!in_ready && t < 100) begin
         @(posedge CLK); #1;
         t++;
      end
      if (!in_ready) timeout_fail("wait_idle");
   endtask

   function automatic logic [31:0] fp(input int s, input int e, input int m);
      return {1'(s), 8'(e), 23'(m)};
   endfunction

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] r;
      logic        exc;
      int          lat;
   } pin_t;

   pin_t pins [6];

   initial begin : driver
      logic [31:0] mr, ra, rb;
      logic        me;
      int          ml, ea, eb, mode;
      bit          mo;
      pins[0] = '{32'h40A00000, 32'h40A00000, 1'b0, 32'h41200000, 1'b0, 4};
      pins[1] = '{32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 1'b0, 6};
      pins[2] = '{32'h40A00000, 32'h40A00000, 1'b1, 32'h00000000, 1'b0, 4};
      pins[3] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b1, 4};
      pins[4] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 0};
      pins[5] = '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 4};

      #12;
      chk1("reset_in_ready", in_ready, 1'b1);
      chk1("reset_out_valid", out_valid, 1'b0);
      chk1("reset_busy", busy, 1'b0);
      chk("reset_result", result, 32'd0);
      chk1("reset_exception", Exception, 1'b0);
      #10 RESETn = 1'b1;
      @(posedge CLK); #1;

      foreach (pins[i]) begin
         ref_op(pins[i].a, pins[i].b, pins[i].sub, mr, me, ml, mo);
         chk("model_pin_result", mr, pins[i].r);
         chk1("model_pin_exc", me, pins[i].exc);
         send(pins[i].a, pins[i].b, pins[i].sub);
         wait_idle();
         chk("pin_result", last_res, pins[i].r);
         chk1("pin_exception", last_exc, pins[i].exc);
         if (pins[i].lat != 0) chk("pin_latency", 32'(last_lat), 32'(pins[i].lat));
      end

      // Consumer stalls for five cycles while a new request is presented.
      out_ready = 1'b0;
      send(32'h40A00000, 32'h40A00000, 1'b0);
      for (int t = 0; t < 20 && !out_valid; t++) begin
         @(posedge CLK); #1;
      end
      if (!out_valid) timeout_fail("bp_out_valid");
      for (int k = 0; k < 5; k++) begin
         a_operand = 32'h3F800000; b_operand = 32'h3F800000; AddBar_Sub = 1'b0; in_valid = 1'b1;
         @(posedge CLK); #1;
         chk1("bp_in_ready", in_ready, 1'b0);
         chk1("bp_out_valid", out_valid, 1'b1);
         chk("bp_result", result, 32'h41200000);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge CLK); #1;
      chk1("bp_release_out_valid", out_valid, 1'b0);
      chk1("bp_release_in_ready", in_ready, 1'b1);

      // Asynchronous reset while 1.0-0.75 is normalising.
      send(32'h3F800000, 32'h3F400000, 1'b1);
      @(posedge CLK); @(posedge CLK); #1;
      chk1("pre_reset_busy", busy, 1'b1);
      #2 RESETn = 1'b0;
      #1;
      chk1("arst_in_ready", in_ready, 1'b1);
      chk1("arst_out_valid", out_valid, 1'b0);
      chk1("arst_busy", busy, 1'b0);
      chk("arst_result", result, 32'd0);
      chk1("arst_exception", Exception, 1'b0);
      @(posedge CLK); #2 RESETn = 1'b1;
      @(posedge CLK); #1;
      send(32'h40000000, 32'h40000000, 1'b0);
      wait_idle();
      chk("post_reset_result", last_res, 32'h40800000);

      for (int n = 0; n < 400; n++) begin
         mode = int'($urandom_range(0, 4));
         case (mode)
            0: begin ra = $urandom; rb = $urandom; end
            1: begin
               ea = int'($urandom_range(1, 254));
               eb = ea + int'($urandom_range(0, 30)) - 15;
               if (eb < 1) eb = 1;
               if (eb > 254) eb = 254;
               ra = fp(int'($urandom_range(0, 1)), ea, int'($urandom));
               rb = fp(int'($urandom_range(0, 1)), eb, int'($urandom));
            end
            2: begin
               ra = fp(int'($urandom_range(0, 1)), int'($urandom_range(1, 254)), int'($urandom));
               rb = {1'($urandom), ra[30:3], 3'($urandom)};
            end
            3: begin
               ra = fp(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom));
               rb = fp(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom));
            end
            default: begin
               ra = fp(int'($urandom_range(0, 1)), int'($urandom_range(240, 254)), int'($urandom));
               rb = fp(int'($urandom_range(0, 1)), int'($urandom_range(240, 254)), int'($urandom));
            end
         endcase
         send(ra, rb, 1'($urandom));
         wait_idle();
      end

      repeat (3) @(posedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
